hex_scan_driver: RTL and testbench
==================================

# hex_scan_driver

Time-multiplexed, parametrised seven-segment driver for NUM_DIGITS hex digits sharing one active-low segment bus. It latches a packed hex word and per-digit decimal points on a load strobe, then scans the digits with a programmable slot period and an anti-ghosting blanking gap. Optional leading-zero suppression is provided. It sits between the top-level debug/score registers and the board's shared segment and digit-enable pins, and replaces one-driver-per-digit wiring.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500, cycles at the end of each slot with all digits off; must satisfy 0 <= BLANK_CYCLES < SCAN_DIV.
- Clk  input  1  system clock; all state is updated on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Load  input  1  when high at a rising edge, captures Data and DP into shadow registers.
- Data  input  4*NUM_DIGITS  packed hex value; digit i is Data[4i+3:4i], and digit 0 is least significant.
- DP  input  NUM_DIGITS  decimal-point request per digit; 1 means the point is lit.
- LZ_En  input  1  leading-zero suppression enable. Sampled live, not latched.
- SEG  output  8  registered segments {dp,g,f,e,d,c,b,a}, active-low.
- AN  output  NUM_DIGITS  registered digit enables, active-low, one-hot or all-ones.

## Operation
- **State registers:**
  - shadow data sd, 4*NUM_DIGITS bits;
  - shadow dp sp, NUM_DIGITS bits;
  - prescaler p, range 0..SCAN_DIV-1;
  - digit index d, range 0..NUM_DIGITS-1;
  - output registers SEG and AN.
- **Reset values:** sd=0, sp=0, p=0, d=0, AN=all ones, SEG=8'hFF. Reset is asynchronous and may occur at any point; it aborts the slot in progress.
- **Load:** sd<=Data and sp<=DP at the edge. No handshake; Load is accepted every cycle it is high. A Load mid-slot changes the lit digit's pattern from the next edge onward.
- **Prescaler and digit index:**
  - If p==SCAN_DIV-1, then p<=0 and d<=(d==NUM_DIGITS-1)?0:d+1.
  - Otherwise p<=p+1.
  - With NUM_DIGITS=1, d stays 0.
- **Digit encoding** (nibble to {g..a}, hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- **Leading-zero suppression:**
  - Digit i is suppressed when LZ_En=1, i>0, and every shadow nibble i..NUM_DIGITS-1 is zero.
  - Digit 0 is never suppressed.
  - A suppressed digit's dp is also dark.
- **Lit condition:** lit = (p < SCAN_DIV-BLANK_CYCLES) && !suppressed(d).
- **Output update, every edge:**
  - If lit: AN <= ~(1<<d) and SEG <= {~sp[d], enc(sd[4d+3:4d])}.
  - Otherwise: AN <= all ones and SEG <= 8'hFF.
- At most one AN bit is low at any time.

## Timing
- Outputs lag the (p,d) state by one cycle.
- The first edge after Reset deasserts drives digit 0, computed from p=0 and d=0.
- Each digit is lit for SCAN_DIV-BLANK_CYCLES consecutive cycles, then dark for BLANK_CYCLES cycles. The full frame is NUM_DIGITS*SCAN_DIV cycles.
- **Load latency:** Load high at edge k changes sd. SEG reflects the new data at edge k+1 if the digit is lit.
- **Simultaneous Load and digit wrap:** both take effect. The new digit index shows the new data one edge later.
- **LZ_En:** a change is visible at the next edge.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.

1. **Reset:** hold Reset -> AN=4'hF and SEG=8'hFF. Assert Reset asynchronously mid-cycle -> outputs go to these values immediately, without waiting for an edge.
2. **Scan order:** Load Data=16'h12AF, DP=4'b0000 after reset.
   - Digit 0: AN=4'b1110 with SEG=8'h8E for 3 cycles, then AN=4'hF for 1 cycle.
   - Then digit 1: AN=4'b1101 with SEG=8'h88.
   - Then digit 2: AN=4'b1011 with SEG=8'hA4.
   - Then digit 3: AN=4'b0111 with SEG=8'hF9.
   - Then the sequence wraps to digit 0.
3. **Decimal point:** Data=16'h0008, DP=4'b0001 -> digit 0 shows SEG=8'h00; the other digits have bit7=1.
4. **Leading-zero suppression:** Data=16'h0050, LZ_En=1 -> digits 3 and 2 keep AN=4'hF during their slots; digit 1 shows SEG=8'h92; digit 0 shows SEG=8'hC0. Data=16'h0000 -> only digit 0 is lit, with SEG=8'hC0. LZ_En=0 -> all four digits are lit, each with SEG=8'hC0.
5. **Load mid-slot and at wrap:**
   - During digit 0's second lit cycle, Load Data=16'h0003 -> the following cycle shows SEG=8'hB0.
   - Load coinciding with p=3, d=3 -> digit 0's first lit cycle shows the new value.
6. **Blanking and one-hot invariant:** run 3 full frames with random Load and DP -> AN is never more than one-hot-low; SEG=8'hFF whenever AN=4'hF.

Source files
------------

// File: rtl/hex_scan_driver.sv
// Time-multiplexed seven-segment driver: NUM_DIGITS hex digits share one active-low
// segment bus and are strobed in turn, with a blanking gap at the end of each slot.
module hex_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Load,
   input  logic [4*NUM_DIGITS-1:0]   Data,
   input  logic [NUM_DIGITS-1:0]     DP,
   input  logic                      LZ_En,
   output logic [7:0]                SEG,
   output logic [NUM_DIGITS-1:0]     AN
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);
   // One extra bit so a zero-length blanking gap still compares correctly.
   localparam logic [PW:0]   LIT_END = (PW + 1)'(SCAN_DIV - BLANK_CYCLES);

   // Hex nibble to {g,f,e,d,c,b,a}, active-low.
   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h40;
         4'h1:    pat = 7'h79;
         4'h2:    pat = 7'h24;
         4'h3:    pat = 7'h30;
         4'h4:    pat = 7'h19;
         4'h5:    pat = 7'h12;
         4'h6:    pat = 7'h02;
         4'h7:    pat = 7'h78;
         4'h8:    pat = 7'h00;
         4'h9:    pat = 7'h10;
         4'hA:    pat = 7'h08;
         4'hB:    pat = 7'h03;
         4'hC:    pat = 7'h46;
         4'hD:    pat = 7'h21;
         4'hE:    pat = 7'h06;
         4'hF:    pat = 7'h0E;
         default: pat = 7'h7F;
      endcase
      return pat;
   endfunction

   logic [4*NUM_DIGITS-1:0] sd_r;
   logic [NUM_DIGITS-1:0]   sp_r;
   logic [PW-1:0]           p_r;
   logic [DW-1:0]           d_r;

   logic [PW-1:0]           p_nxt_s;
   logic [DW-1:0]           d_nxt_s;
   logic [NUM_DIGITS-1:0]   supp_s;
   logic [3:0]              nib_s;
   logic                    lit_s;
   logic [NUM_DIGITS-1:0]   an_nxt_s;
   logic [7:0]              seg_nxt_s;

   // Slot prescaler and round-robin digit index.
   always_comb begin
      p_nxt_s = p_r;
      d_nxt_s = d_r;
      if (p_r == P_LAST) begin
         p_nxt_s = '0;
         if (d_r == D_LAST) begin
            d_nxt_s = '0;
         end else begin
            d_nxt_s = d_r + 1'b1;
         end
      end else begin
         p_nxt_s = p_r + 1'b1;
         d_nxt_s = d_r;
      end
   end

   // A digit is blank when it and every more significant nibble are zero; digit 0 always shows.
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      supp_s     = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (sd_r[4*i +: 4] == 4'h0);
         supp_s[i]  = LZ_En & upper_zero & (i != 0);
      end
   end

   // Pattern for the next output edge.
   always_comb begin
      nib_s     = sd_r[4*d_r +: 4];
      lit_s     = ({1'b0, p_r} < LIT_END) && !supp_s[d_r];
      an_nxt_s  = '1;
      seg_nxt_s = 8'hFF;
      if (lit_s) begin
         an_nxt_s[d_r] = 1'b0;
         seg_nxt_s     = {~sp_r[d_r], seg_encode(nib_s)};
      end else begin
         an_nxt_s  = '1;
         seg_nxt_s = 8'hFF;
      end
   end

   // Shadow capture of the display word and decimal points.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sd_r <= '0;
         sp_r <= '0;
      end else if (Load) begin
         sd_r <= Data;
         sp_r <= DP;
      end
   end

   // Scan position state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         p_r <= '0;
         d_r <= '0;
      end else begin
         p_r <= p_nxt_s;
         d_r <= d_nxt_s;
      end
   end

   // Registered pin drivers, so segment and enable pins change together.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         AN  <= '1;
         SEG <= 8'hFF;
      end else begin
         AN  <= an_nxt_s;
         SEG <= seg_nxt_s;
      end
   end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver: cycle-count based reference model checked on every
// falling edge, plus literal expectations for the scan, dp, suppression and load cases.
module tb_hex_scan_driver;

   logic        Clk;
   logic        Reset;
   logic        Load;
   logic [15:0] Data;
   logic [3:0]  DP;
   logic        LZ_En;
   logic [7:0]  SEG;
   logic [3:0]  AN;

   int n_checks = 0;
   int n_fail   = 0;

   hex_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .Data(Data), .DP(DP),
      .LZ_En(LZ_En), .SEG(SEG), .AN(AN)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Outputs for edge number n since reset: slot position comes straight from n.
   function automatic logic [11:0] model_out(input int n, input logic [15:0] sd,
                                             input logic [3:0] sp, input logic lz);
      int         p;
      int         d;
      bit         sup;
      logic [3:0] an;
      logic [3:0] nib;
      p   = n % 4;
      d   = (n / 4) % 4;
      sup = lz && (d > 0) && ((sd >> (4 * d)) == 16'h0000);
      if (p < 3 && !sup) begin
         an  = ~(4'b0001 << d);
         nib = 4'((sd >> (4 * d)) & 16'h000F);
         return {an, ~sp[d], seg_tab[nib]};
      end
      return {4'hF, 8'hFF};
   endfunction

   int          n_m;
   logic [15:0] sd_m;
   logic [3:0]  sp_m;
   logic [3:0]  exp_an;
   logic [7:0]  exp_seg;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         n_m     <= 0;
         sd_m    <= 16'h0000;
         sp_m    <= 4'h0;
         exp_an  <= 4'hF;
         exp_seg <= 8'hFF;
      end else begin
         {exp_an, exp_seg} <= model_out(n_m, sd_m, sp_m, LZ_En);
         n_m <= n_m + 1;
         if (Load) begin
            sd_m <= Data;
            sp_m <= DP;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      chk("model_an", {28'h0, AN}, {28'h0, exp_an});
      chk("model_seg", {24'h0, SEG}, {24'h0, exp_seg});
      chk("an_onehot", {31'h0, $onehot0(~AN)}, 32'h1);
      if (AN == 4'hF) begin
         chk("seg_dark", {24'h0, SEG}, 32'hFF);
      end
   end

   task automatic tick();
      @(negedge Clk);
      #2;
   endtask

   // Advance until the outputs of edge k (counted from reset release) are showing.
   task automatic wait_to(input int k);
      int guard;
      guard = 0;
      while (n_m < k + 1 && guard < 1000) begin
         tick();
         guard++;
      end
      if (n_m < k + 1) begin
         n_fail++;
         $display("FAIL wait_timeout: got %0d expected %0d", n_m, k + 1);
      end
   endtask

   task automatic restart(input logic [15:0] data, input logic [3:0] dp, input logic lz);
      tick();
      Reset = 1'b1;
      Load  = 1'b1;
      Data  = data;
      DP    = dp;
      LZ_En = lz;
      tick();
      Reset = 1'b0;
      tick();
      Load  = 1'b0;
   endtask

   task automatic lit(input string name, input int k, input logic [3:0] an, input logic [7:0] seg);
      wait_to(k);
      chk({name, "_an"}, {28'h0, AN}, {28'h0, an});
      chk({name, "_seg"}, {24'h0, SEG}, {24'h0, seg});
   endtask

   initial begin
      Reset = 1'b1;
      Load  = 1'b0;
      Data  = 16'h0000;
      DP    = 4'h0;
      LZ_En = 1'b0;
      tick();
      tick();
      chk("reset_an", {28'h0, AN}, 32'hF);
      chk("reset_seg", {24'h0, SEG}, 32'hFF);

      // Scan order
      restart(16'h12AF, 4'b0000, 1'b0);
      lit("d0_first", 1, 4'b1110, 8'h8E);
      lit("d0_last", 2, 4'b1110, 8'h8E);
      lit("d0_blank", 3, 4'hF, 8'hFF);
      lit("d1", 4, 4'b1101, 8'h88);
      lit("d2", 8, 4'b1011, 8'hA4);
      lit("d3", 12, 4'b0111, 8'hF9);
      lit("wrap_d0", 16, 4'b1110, 8'h8E);

      // Asynchronous reset mid-cycle
      wait_to(21);
      #1;
      Reset = 1'b1;
      #1;
      chk("async_an", {28'h0, AN}, 32'hF);
      chk("async_seg", {24'h0, SEG}, 32'hFF);

      // Decimal point
      restart(16'h0008, 4'b0001, 1'b0);
      lit("dp_d0", 1, 4'b1110, 8'h00);
      for (int k = 4; k <= 12; k += 4) begin
         wait_to(k);
         chk("dp_off", {31'h0, SEG[7]}, 32'h1);
      end

      // Leading-zero suppression
      restart(16'h0050, 4'b0000, 1'b1);
      lit("lz_d0", 1, 4'b1110, 8'hC0);
      lit("lz_d1", 4, 4'b1101, 8'h92);
      lit("lz_d2", 8, 4'hF, 8'hFF);
      lit("lz_d3", 12, 4'hF, 8'hFF);
      restart(16'h0000, 4'b1111, 1'b1);
      lit("lz0_d0", 1, 4'b1110, 8'h40);
      lit("lz0_d1", 5, 4'hF, 8'hFF);
      wait_to(5);
      LZ_En = 1'b0;
      lit("lzoff_d2", 9, 4'b1011, 8'h40);
      lit("lzoff_d3", 13, 4'b0111, 8'h40);

      // Load mid-slot and at the digit wrap
      restart(16'h0000, 4'b0000, 1'b0);
      Load = 1'b1;
      Data = 16'h0003;
      tick();
      Load = 1'b0;
      chk("mid_old", {24'h0, SEG}, 32'hC0);
      lit("mid_new", 2, 4'b1110, 8'hB0);
      wait_to(14);
      Load = 1'b1;
      Data = 16'h0007;
      tick();
      Load = 1'b0;
      lit("wrap_load", 16, 4'b1110, 8'hF8);

      // Random loads over several frames against the model
      restart(16'($urandom), 4'($urandom), 1'b0);
      for (int i = 0; i < 64; i++) begin
         Load  = ($urandom_range(0, 3) == 0);
         Data  = 16'($urandom);
         DP    = 4'($urandom);
         LZ_En = 1'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            Data = {12'h000, 4'($urandom)};
         end
         tick();
      end
      Load = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
